// File: rtl/cache_pkg.sv
// Shared constants and refill state encoding for the cache data array.
package cache_pkg;

  localparam int DEFAULT_NUM_BLOCKS      = 128;
  localparam int DEFAULT_WORDS_PER_BLOCK = 8;
  localparam int DEFAULT_DATA_W          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/cache_fill_ctrl.sv
// Block refill sequencer: latches the target block, counts accepted beats and
// emits one write per beat plus busy/done status.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_BLOCKS      = DEFAULT_NUM_BLOCKS,
  parameter int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               fill_start,
  input  logic [$clog2(NUM_BLOCKS)-1:0]      fill_block,
  input  logic                               fill_valid,
  output logic                               fill_busy,
  output logic                               fill_done,
  output logic                               fill_we,
  output logic [$clog2(NUM_BLOCKS)-1:0]      fill_wr_block,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_wr_word
);

  localparam int BW = $clog2(NUM_BLOCKS);
  localparam int WW = $clog2(WORDS_PER_BLOCK);

  fill_state_t   state_q, state_d;
  logic [BW-1:0] block_q, block_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic          beat;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      block_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d = FILL;
          block_d = fill_block;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (fill_valid) begin
          beat = 1'b1;
          if (cnt_q == WW'(WORDS_PER_BLOCK - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fill_busy     = (state_q == FILL);
  assign fill_done     = (state_q == DONE);
  assign fill_we       = beat;
  assign fill_wr_block = block_q;
  assign fill_wr_word  = cnt_q;

endmodule

// File: rtl/cache_data_array.sv
// Cache data storage with a 1-cycle registered read port, a single-word store
// port and a block refill port. Define CACHE_DATA_ARRAY_BYPASS_EN for write-to-read forwarding.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int NUM_BLOCKS      = DEFAULT_NUM_BLOCKS,
  parameter int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
  parameter int DATA_W          = DEFAULT_DATA_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rd_en,
  input  logic [$clog2(NUM_BLOCKS)-1:0]      rd_block,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0] rd_word,
  output logic [DATA_W-1:0]                  rd_data,
  output logic                               rd_valid,
  input  logic                               wr_en,
  input  logic [$clog2(NUM_BLOCKS)-1:0]      wr_block,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0] wr_word,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic                               fill_start,
  input  logic [$clog2(NUM_BLOCKS)-1:0]      fill_block,
  input  logic                               fill_valid,
  input  logic [DATA_W-1:0]                  fill_data,
  output logic                               fill_busy,
  output logic                               fill_done
);

  localparam int BW    = $clog2(NUM_BLOCKS);
  localparam int WW    = $clog2(WORDS_PER_BLOCK);
  localparam int AW    = BW + WW;
  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];

  logic          fill_we;
  logic [BW-1:0] fill_wr_block;
  logic [WW-1:0] fill_wr_word;
  logic          wr_accept;
  logic [AW-1:0] wr_addr, fl_addr, rd_addr;
  logic [DATA_W-1:0] rd_next;

  cache_fill_ctrl #(
    .NUM_BLOCKS     (NUM_BLOCKS),
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
  ) u_fill_ctrl (
    .clk          (clk),
    .rst          (rst),
    .fill_start   (fill_start),
    .fill_block   (fill_block),
    .fill_valid   (fill_valid),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .fill_we      (fill_we),
    .fill_wr_block(fill_wr_block),
    .fill_wr_word (fill_wr_word)
  );

  assign wr_addr = {wr_block, wr_word};
  assign fl_addr = {fill_wr_block, fill_wr_word};
  assign rd_addr = {rd_block, rd_word};

  // Stores to the block under refill are dropped so the refill wins cleanly.
  assign wr_accept = wr_en && !(fill_busy && (wr_block == fill_wr_block));

  // NOTE: the array must clear on reset, so it is built from resettable flops
  // rather than a RAM macro, which cannot be bulk-cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else begin
      if (wr_accept) mem[wr_addr] <= wr_data;
      if (fill_we)   mem[fl_addr] <= fill_data;
    end
  end

`ifdef CACHE_DATA_ARRAY_BYPASS_EN
  // A store and a refill beat never target the same word, so order is moot.
  always_comb begin
    rd_next = mem[rd_addr];
    if (wr_accept && (wr_addr == rd_addr)) begin
      rd_next = wr_data;
    end else if (fill_we && (fl_addr == rd_addr)) begin
      rd_next = fill_data;
    end
  end
`else
  assign rd_next = mem[rd_addr];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_cache_data_array.sv
// Directed bench for cache_data_array: table-driven read/store vectors plus
// hand-written refill, store-drop and reset-mid-refill sequences.
module tb_cache_data_array;

  localparam int NB  = 128;
  localparam int WPB = 8;
  localparam int DW  = 16;
  localparam int BW  = $clog2(NB);
  localparam int WW  = $clog2(WPB);

  logic          clk;
  logic          rst;
  logic          rd_en;
  logic [BW-1:0] rd_block;
  logic [WW-1:0] rd_word;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en;
  logic [BW-1:0] wr_block;
  logic [WW-1:0] wr_word;
  logic [DW-1:0] wr_data;
  logic          fill_start;
  logic [BW-1:0] fill_block;
  logic          fill_valid;
  logic [DW-1:0] fill_data;
  logic          fill_busy;
  logic          fill_done;

  cache_data_array #(
    .NUM_BLOCKS     (NB),
    .WORDS_PER_BLOCK(WPB),
    .DATA_W         (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_block  (rd_block),
    .rd_word   (rd_word),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_block  (wr_block),
    .wr_word   (wr_word),
    .wr_data   (wr_data),
    .fill_start(fill_start),
    .fill_block(fill_block),
    .fill_valid(fill_valid),
    .fill_data (fill_data),
    .fill_busy (fill_busy),
    .fill_done (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr_en;
    logic [BW-1:0] wr_block;
    logic [WW-1:0] wr_word;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [BW-1:0] rd_block;
    logic [WW-1:0] rd_word;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; rd_block = '0; rd_word = '0;
    wr_en = 1'b0; wr_block = '0; wr_word = '0; wr_data = '0;
    fill_start = 1'b0; fill_block = '0; fill_valid = 1'b0; fill_data = '0;
  endtask

  task automatic read_check(input logic [BW-1:0] b, input logic [WW-1:0] w,
                            input logic [DW-1:0] exp, input string name);
    rd_en = 1'b1; rd_block = b; rd_word = w;
    tick();
    rd_en = 1'b0;
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    check({name, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  logic [DW-1:0] same_cycle_exp;

  initial begin
`ifdef CACHE_DATA_ARRAY_BYPASS_EN
    same_cycle_exp = 16'h1234;
`else
    same_cycle_exp = 16'hBEEF;
`endif
    //          wr  blk  wd  wdata     rd  blk  wd  valid edata
    vecs[0]  = '{0, 0,   0, 16'h0000, 1, 5,   3, 1, 16'h0000};
    vecs[1]  = '{1, 7,   2, 16'hBEEF, 0, 0,   0, 0, 16'h0000};
    vecs[2]  = '{0, 0,   0, 16'h0000, 1, 7,   2, 1, 16'hBEEF};
    vecs[3]  = '{1, 7,   2, 16'h1234, 1, 7,   2, 1, same_cycle_exp};
    vecs[4]  = '{0, 0,   0, 16'h0000, 1, 7,   2, 1, 16'h1234};
    vecs[5]  = '{1, 0,   0, 16'h0001, 1, 127, 7, 1, 16'h0000};
    vecs[6]  = '{1, 127, 7, 16'hFFFF, 1, 0,   0, 1, 16'h0001};
    vecs[7]  = '{0, 0,   0, 16'h0000, 1, 127, 7, 1, 16'hFFFF};
    vecs[8]  = '{0, 0,   0, 16'h0000, 0, 0,   0, 0, 16'hFFFF};
    vecs[9]  = '{1, 7,   3, 16'h5555, 1, 7,   2, 1, 16'h1234};
    vecs[10] = '{0, 0,   0, 16'h0000, 1, 7,   3, 1, 16'h5555};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_valid",  32'(rd_valid),  32'd0);
    check("reset_rd_data",   32'(rd_data),   32'd0);
    check("reset_fill_busy", 32'(fill_busy), 32'd0);
    check("reset_fill_done", 32'(fill_done), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      wr_en = vecs[i].wr_en; wr_block = vecs[i].wr_block;
      wr_word = vecs[i].wr_word; wr_data = vecs[i].wr_data;
      rd_en = vecs[i].rd_en; rd_block = vecs[i].rd_block; rd_word = vecs[i].rd_word;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i),  32'(rd_data),  32'(vecs[i].exp_data));
    end
    idle_inputs();
    tick();

    // Refill block 10: 8 beats with one gap, a dropped store, a parallel store,
    // an ignored restart and a read of partially refilled data.
    fill_start = 1'b1; fill_block = 7'd10;
    tick();
    fill_start = 1'b0; fill_block = '0;
    check("fill_busy_after_start", 32'(fill_busy), 32'd1);
    begin
      int beat_n;
      beat_n = 0;
      for (int j = 0; j < 9; j++) begin
        idle_inputs();
        if (j != 3) begin
          fill_valid = 1'b1;
          fill_data  = 16'h1000 + 16'(beat_n);
          beat_n++;
        end
        if (j == 0) begin wr_en = 1'b1; wr_block = 7'd10; wr_word = 3'd0; wr_data = 16'hDEAD; end
        if (j == 2) begin wr_en = 1'b1; wr_block = 7'd11; wr_word = 3'd0; wr_data = 16'hCAFE; end
        if (j == 3) begin rd_en = 1'b1; rd_block = 7'd10; rd_word = 3'd1; end
        if (j == 5) begin fill_start = 1'b1; fill_block = 7'd20; end
        tick();
        if (j == 3) check("partial_fill_read", 32'(rd_data), 32'h1001);
        if (j < 8) begin
          check($sformatf("fill_busy_beat%0d", j), 32'(fill_busy), 32'd1);
          check($sformatf("fill_done_beat%0d", j), 32'(fill_done), 32'd0);
        end else begin
          check("fill_done_pulse", 32'(fill_done), 32'd1);
          check("fill_busy_in_done", 32'(fill_busy), 32'd0);
        end
      end
    end
    idle_inputs();
    fill_start = 1'b1; fill_block = 7'd30;
    tick();
    idle_inputs();
    check("fill_done_one_cycle", 32'(fill_done), 32'd0);
    check("fill_start_in_done_ignored", 32'(fill_busy), 32'd0);

    for (int w = 0; w < WPB; w++) begin
      read_check(7'd10, WW'(w), 16'h1000 + 16'(w), $sformatf("blk10_w%0d", w));
    end
    read_check(7'd11, 3'd0, 16'hCAFE, "blk11_w0_parallel_store");
    read_check(7'd20, 3'd0, 16'h0000, "blk20_not_filled");

    // Reset partway through a refill of block 3.
    fill_start = 1'b1; fill_block = 7'd3;
    tick();
    idle_inputs();
    for (int j = 0; j < 4; j++) begin
      fill_valid = 1'b1;
      fill_data  = 16'h2000 + 16'(j);
      rd_en      = (j == 2);
      rd_block   = 7'd11;
      tick();
    end
    idle_inputs();
    check("pre_reset_busy", 32'(fill_busy), 32'd1);
    check("pre_reset_rd_data", 32'(rd_data), 32'hCAFE);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_busy", 32'(fill_busy), 32'd0);
    check("async_reset_done", 32'(fill_done), 32'd0);
    check("async_reset_rd_data", 32'(rd_data), 32'd0);
    check("async_reset_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    check("reset_hold_done", 32'(fill_done), 32'd0);
    rst = 1'b0;
    fill_valid = 1'b1; fill_data = 16'h7777;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("post_reset_done%0d", j), 32'(fill_done), 32'd0);
      check($sformatf("post_reset_busy%0d", j), 32'(fill_busy), 32'd0);
    end
    idle_inputs();
    for (int w = 0; w < 5; w++) begin
      read_check(7'd3, WW'(w), 16'h0000, $sformatf("rst_blk3_w%0d", w));
    end
    read_check(7'd7,   3'd2, 16'h0000, "rst_blk7_w2");
    read_check(7'd10,  3'd0, 16'h0000, "rst_blk10_w0");
    read_check(7'd11,  3'd0, 16'h0000, "rst_blk11_w0");
    read_check(7'd127, 3'd7, 16'h0000, "rst_blk127_w7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
